// File: rtl/axi_lite_mem_arbiter.sv
// 2:1 AXI-lite arbiter: IFU (read-only) and LSU (read/write) share one memory slave.
// One transaction in flight. Build option ARB_ROUND_ROBIN_EN alternates IFU/LSU on contention.
module axi_lite_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // IFU read master
    input  logic [ADDR_W-1:0]   ifu_araddr_i,
    input  logic                ifu_arvalid_i,
    output logic                ifu_arready_o,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    output logic [1:0]          ifu_rresp_o,
    output logic                ifu_rvalid_o,
    input  logic                ifu_rready_i,
    // LSU read/write master
    input  logic [ADDR_W-1:0]   lsu_araddr_i,
    input  logic                lsu_arvalid_i,
    output logic                lsu_arready_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic [1:0]          lsu_rresp_o,
    output logic                lsu_rvalid_o,
    input  logic                lsu_rready_i,
    input  logic [ADDR_W-1:0]   lsu_awaddr_i,
    input  logic                lsu_awvalid_i,
    output logic                lsu_awready_o,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wstrb_i,
    input  logic                lsu_wvalid_i,
    output logic                lsu_wready_o,
    output logic [1:0]          lsu_bresp_o,
    output logic                lsu_bvalid_o,
    input  logic                lsu_bready_i,
    // Memory slave
    output logic [ADDR_W-1:0]   m_araddr_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic [1:0]          m_rresp_i,
    input  logic                m_rvalid_i,
    output logic                m_rready_o,
    output logic [ADDR_W-1:0]   m_awaddr_o,
    output logic                m_awvalid_o,
    input  logic                m_awready_i,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    output logic                m_wvalid_o,
    input  logic                m_wready_i,
    input  logic [1:0]          m_bresp_i,
    input  logic                m_bvalid_i,
    output logic                m_bready_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRdAddr = 3'd1,
        StRdData = 3'd2,
        StWrAddr = 3'd3,
        StWrResp = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;   // 1: LSU owns the bus, 0: IFU
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic ifu_cand, lsu_rd_cand, lsu_wr_cand, lsu_pri, lsu_wins;
    logic in_idle, grant_ifu, grant_lsu_rd, grant_lsu_wr;
    logic rd_ph, wr_ph, aw_hs, w_hs;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;   // 1: LSU granted last
`endif

    always_comb begin
        ifu_cand    = ifu_arvalid_i;
        lsu_rd_cand = lsu_arvalid_i;
        lsu_wr_cand = lsu_awvalid_i & lsu_wvalid_i;
`ifdef ARB_ROUND_ROBIN_EN
        lsu_pri     = ~last_grant_q;
`else
        lsu_pri     = 1'b1;
`endif
        lsu_wins     = (lsu_rd_cand | lsu_wr_cand) & (~ifu_cand | lsu_pri);
        in_idle      = rst_n & (state_q == StIdle);
        grant_lsu_rd = in_idle & lsu_wins & lsu_rd_cand;
        grant_lsu_wr = in_idle & lsu_wins & ~lsu_rd_cand;
        grant_ifu    = in_idle & ifu_cand & ~lsu_wins;
        rd_ph        = rst_n & (state_q == StRdData);
        wr_ph        = rst_n & (state_q == StWrResp);
        aw_hs        = awvalid_q & m_awready_i;
        w_hs         = wvalid_q & m_wready_i;
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        araddr_d  = araddr_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            StIdle: begin
                if (grant_ifu || grant_lsu_rd) begin
                    owner_d   = grant_lsu_rd;
                    araddr_d  = grant_lsu_rd ? lsu_araddr_i : ifu_araddr_i;
                    arvalid_d = 1'b1;
                    state_d   = StRdAddr;
                end else if (grant_lsu_wr) begin
                    owner_d   = 1'b1;
                    awaddr_d  = lsu_awaddr_i;
                    wdata_d   = lsu_wdata_i;
                    wstrb_d   = lsu_wstrb_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = StWrAddr;
                end
`ifdef ARB_ROUND_ROBIN_EN
                if (grant_ifu || grant_lsu_rd || grant_lsu_wr) begin
                    last_grant_d = ~grant_ifu;
                end
`endif
            end
            StRdAddr: begin
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = StRdData;
                end
            end
            StRdData: begin
                if (m_rvalid_i && m_rready_o) begin
                    state_d = StIdle;
                end
            end
            StWrAddr: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Address and data may complete in either order or together.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                if (m_bvalid_i && lsu_bready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StIdle;
                arvalid_d = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            araddr_q  <= araddr_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign ifu_arready_o = grant_ifu;
    assign lsu_arready_o = grant_lsu_rd;
    assign lsu_awready_o = grant_lsu_wr;
    assign lsu_wready_o  = grant_lsu_wr;

    assign m_araddr_o  = araddr_q;
    assign m_awaddr_o  = awaddr_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = wstrb_q;
    assign m_arvalid_o = rst_n & arvalid_q;
    assign m_awvalid_o = rst_n & awvalid_q;
    assign m_wvalid_o  = rst_n & wvalid_q;

    // Response channels reach only the owner; the other master sees silence.
    assign m_rready_o   = rd_ph & (owner_q ? lsu_rready_i : ifu_rready_i);
    assign ifu_rvalid_o = rd_ph & ~owner_q & m_rvalid_i;
    assign ifu_rdata_o  = (rd_ph & ~owner_q) ? m_rdata_i : '0;
    assign ifu_rresp_o  = (rd_ph & ~owner_q) ? m_rresp_i : 2'b00;
    assign lsu_rvalid_o = rd_ph & owner_q & m_rvalid_i;
    assign lsu_rdata_o  = (rd_ph & owner_q) ? m_rdata_i : '0;
    assign lsu_rresp_o  = (rd_ph & owner_q) ? m_rresp_i : 2'b00;

    assign lsu_bvalid_o = wr_ph & m_bvalid_i;
    assign lsu_bresp_o  = wr_ph ? m_bresp_i : 2'b00;
    assign m_bready_o   = wr_ph & lsu_bready_i;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Randomized bench for axi_lite_mem_arbiter: random masters and slave, checked against a
// transaction-level model of grant order, request forwarding and response routing.
module tb_axi_lite_mem_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = DW / 8;
    localparam int          NCYC = 3000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0;
    logic          ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
    logic          lsu_awvalid = 0, lsu_wvalid = 0, lsu_bready = 0;
    logic [DW-1:0] lsu_wdata = '0, m_rdata = '0;
    logic [SW-1:0] lsu_wstrb = '0;
    logic          m_arready = 0, m_rvalid = 0, m_awready = 0, m_wready = 0, m_bvalid = 0;
    logic [1:0]    m_rresp = '0, m_bresp = '0;

    logic          ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready;
    logic          lsu_bvalid, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic [DW-1:0] ifu_rdata, lsu_rdata, m_wdata;
    logic [1:0]    ifu_rresp, lsu_rresp, lsu_bresp;
    logic [AW-1:0] m_araddr, m_awaddr;
    logic [SW-1:0] m_wstrb;

    axi_lite_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_araddr_i(ifu_araddr), .ifu_arvalid_i(ifu_arvalid), .ifu_arready_o(ifu_arready),
        .ifu_rdata_o(ifu_rdata), .ifu_rresp_o(ifu_rresp), .ifu_rvalid_o(ifu_rvalid),
        .ifu_rready_i(ifu_rready),
        .lsu_araddr_i(lsu_araddr), .lsu_arvalid_i(lsu_arvalid), .lsu_arready_o(lsu_arready),
        .lsu_rdata_o(lsu_rdata), .lsu_rresp_o(lsu_rresp), .lsu_rvalid_o(lsu_rvalid),
        .lsu_rready_i(lsu_rready),
        .lsu_awaddr_i(lsu_awaddr), .lsu_awvalid_i(lsu_awvalid), .lsu_awready_o(lsu_awready),
        .lsu_wdata_i(lsu_wdata), .lsu_wstrb_i(lsu_wstrb), .lsu_wvalid_i(lsu_wvalid),
        .lsu_wready_o(lsu_wready),
        .lsu_bresp_o(lsu_bresp), .lsu_bvalid_o(lsu_bvalid), .lsu_bready_i(lsu_bready),
        .m_araddr_o(m_araddr), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
        .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
        .m_awaddr_o(m_awaddr), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
        .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
        .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready)
    );

    int unsigned n_vec = 0, n_err = 0, n_done = 0;

    // Transaction-level model: one transfer owns the slave from grant to response.
    bit            busy = 0, ar_pend = 0, aw_pend = 0, w_pend = 0, rd_ph = 0, wr_ph = 0;
    bit            cur_lsu = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [DW-1:0] cur_data = '0;
    logic [SW-1:0] cur_strb = '0;
    bit            s_rvalid = 0, s_bvalid = 0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = '0, s_bresp = '0;
    int            s_delay = 0, w_lag = 0, rst_cnt = 3;
    bit            g_ifu = 0, g_lr = 0, g_lw = 0, hs_ar = 0, hs_aw = 0, hs_w = 0;
    bit            hs_r = 0, hs_b = 0, prev_rst = 1, mid_rst_done = 0;
`ifdef ARB_ROUND_ROBIN_EN
    bit            last_lsu = 0;
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick_resp();
        return ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    endfunction

    // Fold the handshakes decided last cycle into the model (the clock edge has passed).
    task automatic apply_edge();
        if (prev_rst) begin
            busy = 0; ar_pend = 0; aw_pend = 0; w_pend = 0; rd_ph = 0; wr_ph = 0;
            s_rvalid = 0; s_bvalid = 0;
            ifu_arvalid = 0; lsu_arvalid = 0; lsu_awvalid = 0; lsu_wvalid = 0;
`ifdef ARB_ROUND_ROBIN_EN
            last_lsu = 0;
`endif
            return;
        end
        if (g_ifu || g_lr) begin
            busy = 1; ar_pend = 1; cur_lsu = g_lr;
            cur_addr = g_lr ? lsu_araddr : ifu_araddr;
            if (g_lr) lsu_arvalid = 0; else ifu_arvalid = 0;
        end
        if (g_lw) begin
            busy = 1; aw_pend = 1; w_pend = 1; cur_lsu = 1;
            cur_addr = lsu_awaddr; cur_data = lsu_wdata; cur_strb = lsu_wstrb;
            lsu_awvalid = 0; lsu_wvalid = 0;
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (g_ifu || g_lr || g_lw) last_lsu = !g_ifu;
`endif
        if (hs_ar) begin
            ar_pend = 0; rd_ph = 1; s_delay = $urandom_range(0, 4);
        end
        if (hs_aw) aw_pend = 0;
        if (hs_w) w_pend = 0;
        if ((hs_aw || hs_w) && !aw_pend && !w_pend) begin
            wr_ph = 1; s_delay = $urandom_range(0, 4);
        end
        if (hs_r) begin rd_ph = 0; busy = 0; s_rvalid = 0; n_done++; end
        if (hs_b) begin wr_ph = 0; busy = 0; s_bvalid = 0; n_done++; end
    endtask

    task automatic drive_inputs(input int cyc);
        int p;
        if (!mid_rst_done && cyc >= 1200 && rd_ph) begin
            rst_cnt = 2; mid_rst_done = 1;
        end
        if (rst_cnt > 0) begin
            // Inputs toggle freely under reset; every handshake output must stay low.
            rst_cnt--; rst_n = 0;
            ifu_arvalid = 1'($urandom); lsu_arvalid = 1'($urandom);
            lsu_awvalid = 1'($urandom); lsu_wvalid = 1'($urandom);
            m_arready = 1'($urandom); m_rvalid = 1'($urandom); m_awready = 1'($urandom);
            m_wready = 1'($urandom); m_bvalid = 1'($urandom);
            ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
            return;
        end
        rst_n = 1;
        p = (cyc < 900) ? 60 : 20;
        if (!ifu_arvalid && $urandom_range(0, 99) < p) begin
            ifu_arvalid = 1; ifu_araddr = $urandom;
        end
        if (!lsu_arvalid && $urandom_range(0, 99) < p / 2) begin
            lsu_arvalid = 1; lsu_araddr = $urandom;
        end
        if (!lsu_awvalid && $urandom_range(0, 99) < p / 2) begin
            lsu_awvalid = 1; lsu_awaddr = $urandom; lsu_wdata = $urandom;
            lsu_wstrb = SW'($urandom_range(1, (1 << SW) - 1));
            w_lag = $urandom_range(0, 5);
            lsu_wvalid = (w_lag == 0);
        end else if (lsu_awvalid && !lsu_wvalid) begin
            w_lag--;
            lsu_wvalid = (w_lag <= 0);
        end
        ifu_rready = ($urandom_range(0, 3) != 0);
        lsu_rready = ($urandom_range(0, 3) != 0);
        lsu_bready = ($urandom_range(0, 3) != 0);
        m_arready = 1'($urandom);
        m_awready = 1'($urandom);
        m_wready  = 1'($urandom);
        if (rd_ph && !s_rvalid) begin
            if (s_delay == 0) begin
                s_rvalid = 1; s_rdata = $urandom; s_rresp = pick_resp();
            end else s_delay--;
        end
        if (wr_ph && !s_bvalid) begin
            if (s_delay == 0) begin
                s_bvalid = 1; s_bresp = pick_resp();
            end else s_delay--;
        end
        m_rvalid = s_rvalid;
        m_rdata  = s_rvalid ? s_rdata : $urandom;
        m_rresp  = s_rvalid ? s_rresp : 2'($urandom);
        m_bvalid = s_bvalid;
        m_bresp  = s_bvalid ? s_bresp : 2'($urandom);
    endtask

    task automatic check_cycle();
        bit ifu_c, lr_c, lw_c, lsu_first, e_ifu, e_lr, e_lw, e_rready;
        if (!rst_n) begin
            check_eq("rst_hs_outs", {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid,
                     lsu_awready, lsu_wready, lsu_bvalid, m_arvalid, m_rready, m_awvalid,
                     m_wvalid, m_bready}, '0);
            if (prev_rst) begin
                check_eq("rst_araddr", m_araddr, '0);
                check_eq("rst_awaddr", m_awaddr, '0);
                check_eq("rst_wdata", m_wdata, '0);
                check_eq("rst_wstrb", m_wstrb, '0);
                check_eq("rst_rdata", {ifu_rdata, lsu_rdata}, '0);
                check_eq("rst_resp", {ifu_rresp, lsu_rresp, lsu_bresp}, '0);
            end
            {g_ifu, g_lr, g_lw, hs_ar, hs_aw, hs_w, hs_r, hs_b} = '0;
            prev_rst = 1;
            return;
        end
        prev_rst = 0;
        ifu_c = ifu_arvalid; lr_c = lsu_arvalid; lw_c = lsu_awvalid && lsu_wvalid;
        lsu_first = 1;
`ifdef ARB_ROUND_ROBIN_EN
        lsu_first = !last_lsu;
`endif
        {e_ifu, e_lr, e_lw} = '0;
        if (!busy && (ifu_c || lr_c || lw_c)) begin
            if ((lr_c || lw_c) && (!ifu_c || lsu_first)) begin
                if (lr_c) e_lr = 1; else e_lw = 1;
            end else e_ifu = 1;
        end
        check_eq("ifu_arready", ifu_arready, e_ifu);
        check_eq("lsu_arready", lsu_arready, e_lr);
        check_eq("lsu_awready", lsu_awready, e_lw);
        check_eq("lsu_wready", lsu_wready, e_lw);
        check_eq("m_arvalid", m_arvalid, ar_pend);
        check_eq("m_awvalid", m_awvalid, aw_pend);
        check_eq("m_wvalid", m_wvalid, w_pend);
        if (ar_pend) check_eq("m_araddr", m_araddr, cur_addr);
        if (aw_pend) check_eq("m_awaddr", m_awaddr, cur_addr);
        if (w_pend) begin
            check_eq("m_wdata", m_wdata, cur_data);
            check_eq("m_wstrb", m_wstrb, cur_strb);
        end
        e_rready = rd_ph && (cur_lsu ? lsu_rready : ifu_rready);
        check_eq("m_rready", m_rready, e_rready);
        check_eq("ifu_rvalid", ifu_rvalid, rd_ph && !cur_lsu && s_rvalid);
        check_eq("lsu_rvalid", lsu_rvalid, rd_ph && cur_lsu && s_rvalid);
        if (rd_ph && s_rvalid) begin
            check_eq("owner_rdata", cur_lsu ? lsu_rdata : ifu_rdata, s_rdata);
            check_eq("owner_rresp", cur_lsu ? lsu_rresp : ifu_rresp, s_rresp);
        end
        check_eq("m_bready", m_bready, wr_ph && lsu_bready);
        check_eq("lsu_bvalid", lsu_bvalid, wr_ph && s_bvalid);
        if (wr_ph && s_bvalid) check_eq("lsu_bresp", lsu_bresp, s_bresp);
        g_ifu = e_ifu; g_lr = e_lr; g_lw = e_lw;
        hs_ar = ar_pend && m_arready;
        hs_aw = aw_pend && m_awready;
        hs_w  = w_pend && m_wready;
        hs_r  = s_rvalid && e_rready;
        hs_b  = s_bvalid && wr_ph && lsu_bready;
    endtask

    initial begin
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            apply_edge();
            drive_inputs(cyc);
            #1;
            check_cycle();
        end
        check_eq("progress", 64'(n_done > 100), 64'd1);
        check_eq("mid_reset_hit", 64'(mid_rst_done), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- 2-master to 1-slave AXI-lite arbiter that shares the single memory slave (SRAM model) between the IFU (read-only master) and the LSU (read/write master).
- Sits between the core's fetch/load-store units and the memory slave.
- At most one transaction outstanding at any time.
- Latches the winning request's address/data into registers, drives the slave from those registers, and routes the slave's response back to the owner only.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (WSTRB width = DATA_W/8)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
ifu_ar{addr,valid,ready}  in/in/out  ADDR_W/1/1  IFU read-address channel
ifu_r{data,resp,valid,ready}  out/out/out/in  DATA_W/2/1/1  IFU read-data channel
lsu_ar{addr,valid,ready}  in/in/out  ADDR_W/1/1  LSU read-address channel
lsu_r{data,resp,valid,ready}  out/out/out/in  DATA_W/2/1/1  LSU read-data channel
lsu_aw{addr,valid,ready}  in/in/out  ADDR_W/1/1  LSU write-address channel
lsu_w{data,strb,valid,ready}  in/in/in/out  DATA_W/DATA_W/8/1/1  LSU write-data channel
lsu_b{resp,valid,ready}  out/out/in  2/1/1  LSU write-response channel
m_ar{addr,valid,ready}  out/out/in  ADDR_W/1/1  slave read-address channel
m_r{data,resp,valid,ready}  in/in/in/out  DATA_W/2/1/1  slave read-data channel
m_aw{addr,valid,ready}  out/out/in  ADDR_W/1/1  slave write-address channel
m_w{data,strb,valid,ready}  out/out/out/in  DATA_W/DATA_W/8/1/1  slave write-data channel
m_b{resp,valid,ready}  in/in/out  2/1/1  slave write-response channel

Behaviour:
- Clock and reset: clk, single clock domain. rst_n is synchronous and active-low.
- Reset values: state=IDLE; all valid/ready outputs 0; m_araddr/m_awaddr/m_wdata/m_wstrb registers 0; ifu_rdata/lsu_rdata 0; resp outputs 2'b00. While rst_n=0, every ready/valid output is forced 0 combinationally.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. Register owner (IFU/LSU) is set on grant.
- IDLE candidates: IFU read (ifu_arvalid), LSU read (lsu_arvalid), LSU write (lsu_awvalid && lsu_wvalid both high; a lone AW or W is not a candidate).
- LSU-internal priority: read before write.
- Inter-master priority, default: LSU over IFU.
- Grant (IDLE, ≥1 candidate): combinationally pulse the winner's arready, or awready+wready together, for one cycle.
  - Latch addr (plus data/strb for writes) at that edge.
  - Next state is RD_ADDR or WR_ADDR.
  - Losers see ready=0.
- IDLE with no candidate: all readies 0, stay in IDLE.
- RD_ADDR: m_arvalid=1 with the latched address until m_arready; then go to RD_DATA. m_arvalid never drops before its handshake.
- RD_DATA:
  - m_rready = owner's rready.
  - Owner's rvalid/rdata/rresp = m_r* (combinational pass-through). Non-owner rvalid=0.
  - On m_rvalid && m_rready, go to IDLE.
- WR_ADDR:
  - m_awvalid and m_wvalid are asserted independently.
  - Flags aw_done/w_done set on their respective handshakes; each valid drops after its own handshake.
  - When both are done (same or different cycles), clear the flags and go to WR_RESP.
- WR_RESP: lsu_b* <-> m_b* pass-through; on m_bvalid && m_bready, go to IDLE. IFU sees no activity.
- Latency: request accepted at edge N; m_arvalid/m_awvalid high in cycle N+1. Minimum of 1 idle-arbitration cycle between back-to-back transactions (new grant in the cycle after returning to IDLE).
- Slave response errors (resp≠0) are forwarded unchanged; the arbiter takes no other action on them.
- Reset mid-transaction: state returns to IDLE and all flags clear; the in-flight transaction is abandoned.
- Unmapped or invalid state encodings go to IDLE.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - 1-bit last_grant register, reset value = IFU.
  - On IFU-vs-LSU contention in IDLE, the master that was not granted last wins.
  - last_grant updates on every grant.
- Undefined: fixed priority, LSU over IFU. No last_grant register.
- LSU read-before-write priority is unchanged in both modes.

Test Plan:
- IFU-only read: ifu_araddr=0x80000000, slave returns 0x00000413 after 4 cycles -> m_arvalid high the cycle after grant; ifu_rdata=0x00000413; lsu_rvalid stays 0.
- Simultaneous requests: IFU read 0x80000004 and LSU read 0x80001000 same cycle.
  - Default: LSU granted first, IFU second.
  - ARB_ROUND_ROBIN_EN (after reset, last_grant = IFU): LSU first; a repeat contention then grants IFU.
- LSU write: awaddr=0x80002000, wdata=0xDEADBEEF, wstrb=4'hF; slave m_awready 2 cycles before m_wready -> m_awvalid drops after its handshake, m_wvalid held until its own; lsu_bvalid forwarded; return to IDLE.
- Lone lsu_awvalid without lsu_wvalid for 5 cycles while IFU requests -> IFU granted; no LSU write grant.
- Backpressure: owner holds rready=0 for 3 cycles while m_rvalid=1 -> m_rready=0, data stable, state stays RD_DATA.
- rst_n low during RD_DATA -> next cycle state IDLE; all valids/readies 0; new IFU request granted normally after release.
